// File: rtl/inst_fetch_buffer.sv
// Instruction fetch stage between InstCache and InstQueue: single-outstanding
// credit-gated fetch, BUF_DEPTH-entry FIFO, ROB redirect flush; optional JAL predict via FETCH_PREDICT_EN.
module inst_fetch_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int BUF_DEPTH  = 4,
    parameter int BUF_PTR_W  = 2,
    parameter logic [ADDR_WIDTH-1:0] PC_STEP  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  InstCache_inst_valid,
    input  logic [INST_WIDTH-1:0] InstCache_inst,
    output logic                  InstCache_inst_read_valid,
    output logic [ADDR_WIDTH-1:0] InstCache_inst_addr,
    input  logic                  InstQueue_queue_is_full,
    output logic                  InstQueue_inst_valid,
    output logic [INST_WIDTH-1:0] InstQueue_inst,
    output logic [ADDR_WIDTH-1:0] InstQueue_pc,
    output logic                  InstQueue_pred_taken,
    input  logic                  ROB_jump_judge,
    input  logic [ADDR_WIDTH-1:0] ROB_pc
);

    localparam logic [BUF_PTR_W-1:0] PTR_ONE = {{(BUF_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [BUF_PTR_W:0]   CNT_ONE = {{BUF_PTR_W{1'b0}}, 1'b1};
    localparam logic [BUF_PTR_W+1:0] DEPTH_L = (BUF_PTR_W+2)'(BUF_DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  outstanding;
    logic                  drop;

    logic [INST_WIDTH-1:0] inst_mem [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [BUF_DEPTH];
    logic [BUF_PTR_W-1:0]  wr_ptr;
    logic [BUF_PTR_W-1:0]  rd_ptr;
    logic [BUF_PTR_W:0]    count;

    logic                  resp;
    logic                  redirect;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [BUF_PTR_W+1:0]  credit_used;

`ifdef FETCH_PREDICT_EN
    logic                  pred_mem [BUF_DEPTH];
    logic                  is_jal;
    logic [ADDR_WIDTH-1:0] jal_imm;
    logic [ADDR_WIDTH-1:0] jal_target;
    logic                  q_pred;

    assign is_jal     = (InstCache_inst[6:0] == 7'b1101111);
    assign jal_imm    = {{(ADDR_WIDTH-20){InstCache_inst[31]}},
                         InstCache_inst[19:12], InstCache_inst[20],
                         InstCache_inst[30:21], 1'b0};
    assign jal_target = req_pc + jal_imm;
    assign InstQueue_pred_taken = q_pred;
`else
    assign InstQueue_pred_taken = 1'b0;
`endif

    // Handshake qualifiers; a redirect overrides push, pop and issue alike
    always_comb begin
        resp        = InstCache_inst_valid && outstanding;
        redirect    = ROB_jump_judge;
        push        = resp && !drop && !redirect;
        pop         = (count != '0) && !InstQueue_queue_is_full && !redirect;
        credit_used = {1'b0, count} + {{(BUF_PTR_W+1){1'b0}}, outstanding};
        issue       = !outstanding && !redirect && (credit_used < DEPTH_L);
    end

    // Fetch PC, request pulse and outstanding/stale-response tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc                  <= RESET_PC;
            req_pc                    <= '0;
            outstanding               <= 1'b0;
            drop                      <= 1'b0;
            InstCache_inst_read_valid <= 1'b0;
            InstCache_inst_addr       <= '0;
        end else if (rdy) begin
            InstCache_inst_read_valid <= 1'b0;
            InstCache_inst_addr       <= '0;
            if (resp) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
            if (redirect) begin
                fetch_pc <= ROB_pc;
                if (outstanding && !InstCache_inst_valid)
                    drop <= 1'b1;
            end else if (issue) begin
                InstCache_inst_read_valid <= 1'b1;
                InstCache_inst_addr       <= fetch_pc;
                req_pc                    <= fetch_pc;
                fetch_pc                  <= fetch_pc + PC_STEP;
                outstanding               <= 1'b1;
            end
`ifdef FETCH_PREDICT_EN
            else if (push && is_jal) begin
                fetch_pc <= jal_target;
            end
`endif
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rdy) begin
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)
                    rd_ptr <= rd_ptr + PTR_ONE;
                unique case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy guards reads
    always_ff @(posedge clk) begin
        if (rdy && push) begin
            inst_mem[wr_ptr] <= InstCache_inst;
            pc_mem[wr_ptr]   <= req_pc;
`ifdef FETCH_PREDICT_EN
            pred_mem[wr_ptr] <= is_jal;
`endif
        end
    end

    // Registered push toward InstQueue; data is zero whenever no push
    always_ff @(posedge clk) begin
        if (rst) begin
            InstQueue_inst_valid <= 1'b0;
            InstQueue_inst       <= '0;
            InstQueue_pc         <= '0;
`ifdef FETCH_PREDICT_EN
            q_pred               <= 1'b0;
`endif
        end else if (rdy) begin
            InstQueue_inst_valid <= pop;
            InstQueue_inst       <= pop ? inst_mem[rd_ptr] : '0;
            InstQueue_pc         <= pop ? pc_mem[rd_ptr] : '0;
`ifdef FETCH_PREDICT_EN
            q_pred               <= pop ? pred_mem[rd_ptr] : 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: cycle vector table plus directed sequences
// for back-pressure, redirect flush, rdy freeze and JAL prediction.
module tb_inst_fetch_buffer;

    localparam int BUF_DEPTH = 4;

`ifdef FETCH_PREDICT_EN
    localparam logic [31:0] T6_A1   = 32'h110;
    localparam logic [31:0] T6_A2   = 32'h120;
    localparam logic [31:0] T6_PC2  = 32'h110;
    localparam logic        T6_PRED = 1'b1;
`else
    localparam logic [31:0] T6_A1   = 32'h14;
    localparam logic [31:0] T6_A2   = 32'h18;
    localparam logic [31:0] T6_PC2  = 32'h14;
    localparam logic        T6_PRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        c_valid = 1'b0;
    logic [31:0] c_inst = '0;
    logic        c_rv;
    logic [31:0] c_addr;
    logic        q_full = 1'b0;
    logic        q_valid;
    logic [31:0] q_inst;
    logic [31:0] q_pc;
    logic        q_pred;
    logic        jump = 1'b0;
    logic [31:0] rob_pc = '0;

    int asserts = 0;
    int errors  = 0;

    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        jal_mode = 1'b0;
    logic        mon_en = 1'b0;
    logic [31:0] exp_pc = '0;
    int          pops = 0;
    int          rv_cnt = 0;

    typedef struct {
        logic        rst;
        logic        jump;
        logic [31:0] rob_pc;
        logic        rv;
        logic [31:0] addr;
        logic        qv;
        logic [31:0] qpc;
    } vec_t;

    vec_t tbl[$];

    inst_fetch_buffer dut (
        .clk                       (clk),
        .rst                       (rst),
        .rdy                       (rdy),
        .InstCache_inst_valid      (c_valid),
        .InstCache_inst            (c_inst),
        .InstCache_inst_read_valid (c_rv),
        .InstCache_inst_addr       (c_addr),
        .InstQueue_queue_is_full   (q_full),
        .InstQueue_inst_valid      (q_valid),
        .InstQueue_inst            (q_inst),
        .InstQueue_pc              (q_pc),
        .InstQueue_pred_taken      (q_pred),
        .ROB_jump_judge            (jump),
        .ROB_pc                    (rob_pc)
    );

    always #5 clk = ~clk;

    // a push that meets a full FIFO without a pop is a design error
    always @(negedge clk) begin
        if (rst === 1'b0 && rdy && dut.push && !dut.pop
            && int'(dut.count) == BUF_DEPTH) begin
            errors++;
            $display("FAIL fifo_overflow: push into full FIFO at %0t", $time);
        end
    end

    function automatic logic [31:0] inst_of(logic [31:0] a);
        if (jal_mode && a == 32'h10)  return 32'h1000006F; // jal x0,+0x100
        if (jal_mode && a == 32'h110) return 32'h0100006F; // jal x0,+0x10
        return {a[23:0], 8'h13};
    endfunction

    function automatic vec_t v(logic r, logic j, logic [31:0] rp,
                               logic rv, logic [31:0] a,
                               logic qv, logic [31:0] qp);
        vec_t t;
        t.rst = r; t.jump = j; t.rob_pc = rp;
        t.rv = rv; t.addr = a; t.qv = qv; t.qpc = qp;
        return t;
    endfunction

    function automatic vec_t idle();
        return v(0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one clock; cache model answers each request one cycle later
    task automatic step();
        @(posedge clk);
        #1;
        if (rst) begin
            pend = 1'b0; c_valid = 1'b0; c_inst = '0;
        end else if (rdy) begin
            c_valid = 1'b0; c_inst = '0;
            if (pend) begin
                c_valid = 1'b1; c_inst = inst_of(pend_addr); pend = 1'b0;
            end
            if (c_rv) begin
                pend = 1'b1; pend_addr = c_addr; rv_cnt++;
            end
            if (mon_en && q_valid) begin
                chk("mon_pc", q_pc, exp_pc);
                chk("mon_inst", q_inst, inst_of(exp_pc));
                exp_pc += 32'd4;
                pops++;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; jump = 1'b0; q_full = 1'b0;
        mon_en = 1'b0; jal_mode = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        // test 1: sequential stream
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 32'h0, 0, 0));
        tbl.push_back(idle()); tbl.push_back(idle());
        tbl.push_back(v(0, 0, 0, 1, 32'h4, 1, 32'h0));
        tbl.push_back(idle()); tbl.push_back(idle());
        tbl.push_back(v(0, 0, 0, 1, 32'h8, 1, 32'h4));
        tbl.push_back(idle()); tbl.push_back(idle());
        tbl.push_back(v(0, 0, 0, 1, 32'hC, 1, 32'h8));
        tbl.push_back(idle()); tbl.push_back(idle());
        tbl.push_back(v(0, 0, 0, 1, 32'h10, 1, 32'hC));
        // test 3: redirect while request 0x8 outstanding
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 32'h0, 0, 0));
        tbl.push_back(idle()); tbl.push_back(idle());
        tbl.push_back(v(0, 0, 0, 1, 32'h4, 1, 32'h0));
        tbl.push_back(idle()); tbl.push_back(idle());
        tbl.push_back(v(0, 0, 0, 1, 32'h8, 1, 32'h4));
        tbl.push_back(v(0, 1, 32'h100, 0, 0, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(v(0, 0, 0, 1, 32'h100, 0, 0));
        tbl.push_back(idle()); tbl.push_back(idle());
        tbl.push_back(v(0, 0, 0, 1, 32'h104, 1, 32'h100));
        // test 4: redirect with response, then back-to-back redirect
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 32'h0, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(v(0, 1, 32'h200, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 32'h300, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 32'h300, 0, 0));
        tbl.push_back(idle()); tbl.push_back(idle());
        tbl.push_back(v(0, 0, 0, 1, 32'h304, 1, 32'h300));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; jump = tbl[i].jump; rob_pc = tbl[i].rob_pc;
            rdy = 1'b1; q_full = 1'b0;
            step();
            chk($sformatf("row%0d read_valid", i), 32'(c_rv), 32'(tbl[i].rv));
            if (tbl[i].rv)
                chk($sformatf("row%0d addr", i), c_addr, tbl[i].addr);
            chk($sformatf("row%0d q_valid", i), 32'(q_valid), 32'(tbl[i].qv));
            chk($sformatf("row%0d q_pc", i), q_pc, tbl[i].qpc);
            chk($sformatf("row%0d q_inst", i), q_inst,
                tbl[i].qv ? inst_of(tbl[i].qpc) : 32'h0);
            chk($sformatf("row%0d q_pred", i), 32'(q_pred), 32'h0);
        end
        jump = 1'b0;

        // test 2: queue full for 20 cycles, then drain in order
        do_reset();
        q_full = 1'b1; mon_en = 1'b1; exp_pc = '0; pops = 0; rv_cnt = 0;
        repeat (20) step();
        chk("t2_reqs_while_full", rv_cnt, 4);
        chk("t2_pops_while_full", pops, 0);
        q_full = 1'b0;
        repeat (40) step();
        chk("t2_drain_progress", 32'(pops >= 8), 32'h1);

        // test 2b: redirect flushes a full FIFO
        do_reset();
        q_full = 1'b1;
        repeat (14) step();
        q_full = 1'b0; jump = 1'b1; rob_pc = 32'h400;
        step();
        chk("t2b_flush_q_valid", 32'(q_valid), 32'h0);
        chk("t2b_flush_read_valid", 32'(c_rv), 32'h0);
        jump = 1'b0; exp_pc = 32'h400; pops = 0; mon_en = 1'b1;
        repeat (10) step();
        chk("t2b_pops_after_flush", 32'(pops >= 1), 32'h1);

        // test 5: rdy low for 5 cycles mid-stream
        do_reset();
        mon_en = 1'b1; exp_pc = '0; pops = 0;
        repeat (4) step();
        chk("t5_pops_before", pops, 1);
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t5_frz%0d_rv", k), 32'(c_rv), 32'h1);
            chk($sformatf("t5_frz%0d_addr", k), c_addr, 32'h4);
            chk($sformatf("t5_frz%0d_qv", k), 32'(q_valid), 32'h1);
            chk($sformatf("t5_frz%0d_qpc", k), q_pc, 32'h0);
        end
        rdy = 1'b1;
        repeat (15) step();
        chk("t5_pops_after", pops, 6);

        // test 6: JAL responses at 0x10 and 0x110
        do_reset();
        jal_mode = 1'b1;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                step();
                if (c_rv && c_addr == 32'h10) seen = 1'b1;
            end
            chk("t6_req_0x10_seen", 32'(seen), 32'h1);
        end
        repeat (3) step();
        chk("t6_next_addr", c_addr, T6_A1);
        chk("t6_q_valid", 32'(q_valid), 32'h1);
        chk("t6_q_pc", q_pc, 32'h10);
        chk("t6_q_inst", q_inst, 32'h1000006F);
        chk("t6_pred", 32'(q_pred), 32'(T6_PRED));
        repeat (3) step();
        chk("t6_next_addr2", c_addr, T6_A2);
        chk("t6_q_pc2", q_pc, T6_PC2);
        chk("t6_q_inst2", q_inst, inst_of(T6_PC2));
        chk("t6_pred2", 32'(q_pred), 32'(T6_PRED));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, errors);
        $finish;
    end

endmodule
